// File: rtl/video_timing_pkg.sv
// video_timing_pkg: standard raster mode constants and total-size helpers.
// Latency: none (constants and elaboration-time functions only).
// Backpressure: not applicable.
package video_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz nominal pixel clock
    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;

    // 800x600 @ 60 Hz, 40 MHz nominal pixel clock
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    // Pixels per line including blanking.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_pix_clk_en_div.sv
// pix_clk_en_div: divides clk into a one-clk pixel tick every CLK_DIV enabled cycles.
// Latency: tick is combinational from the divider register; it is high in the cycle whose edge advances a pixel.
// Backpressure: none; enable low freezes the divider so counting resumes where it stopped.
module pix_clk_en_div #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    assign tick = enable && (div == DIV_LAST);

    // Divider counts enabled clocks and wraps on the tick; holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else if (enable) begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters with registered sync/DE/coordinate/strobe decode.
// Latency: all raster outputs change on the pixel-tick edge; pix_en rises on the following edge.
// Backpressure: none; enable low freezes divider, counters and outputs. Option macro: VTG_FRAME_CNT_EN adds frame_cnt.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter int CLK_DIV    = 10,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int     H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int     MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam longint CAPACITY  = longint'(1) << CW;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("video_timing_gen: CLK_DIV and every timing parameter must be >= 1");
    end
    if (CAPACITY < longint'(MAX_TOTAL)) begin : g_bad_cw
        $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic          tick;
    logic          tick_q;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_wrap;
    logic          de_nxt;
    logic          hs_act;
    logic          vs_act;

    pix_clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Next raster position and its decode; vertical only steps on the line wrap, so vsync moves only at x==0.
    always_comb begin
        h_wrap = (h == H_LAST);
        h_nxt  = h_wrap ? '0 : h + 1'b1;
        v_nxt  = v;
        if (h_wrap) begin
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
        de_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_act = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
        vs_act = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    end

    // Counters start at the last position so the first tick lands on (0,0); outputs load from the new position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= H_LAST;
            v           <= V_LAST;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            blank       <= 1'b1;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick) begin
            h           <= h_nxt;
            v           <= v_nxt;
            x           <= h_nxt;
            y           <= v_nxt;
            de          <= de_nxt;
            blank       <= ~de_nxt;
            hsync       <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // pix_en marks the clk after an output update; forced low whenever enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            pix_en <= 1'b0;
        end else begin
            tick_q <= tick;
            pix_en <= tick_q && enable;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    // Frame counter steps on every edge that loads frame_start high; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (tick && (h_nxt == '0) && (v_nxt == '0)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
